// File: rtl/mic_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mic_stream_ctrl_if
// Description : Command, microphone, keyboard and transmit signals of the
//               microphone stream controller, bundled with directional views.
// Revision    : 1.0 - initial release
// ============================================================================
interface mic_stream_ctrl_if;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic        record_start;
    logic        record_stop;
    logic [31:0] mic_data;
    logic        mic_data_valid;
    logic        mic_data_retrieved;
    logic [31:0] kbd_data;
    logic        kbd_valid;
    logic        kbd_ack;
    logic [31:0] tx_data;
    logic [1:0]  tx_kind;
    logic        tx_valid;
    logic        tx_ready;
    logic        recording;
    logic        starve;

    // Controller side
    modport master (
        input  cmd_valid, cmd_code, mic_data, mic_data_valid,
               kbd_data, kbd_valid, tx_ready,
        output record_start, record_stop, mic_data_retrieved, kbd_ack,
               tx_data, tx_kind, tx_valid, recording, starve
    );

    // Environment side: host, microphone, keyboard and transmitter
    modport slave (
        output cmd_valid, cmd_code, mic_data, mic_data_valid,
               kbd_data, kbd_valid, tx_ready,
        input  record_start, record_stop, mic_data_retrieved, kbd_ack,
               tx_data, tx_kind, tx_valid, recording, starve
    );
endinterface
`default_nettype wire

// File: rtl/mic_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mic_stream_ctrl
// Description : Record sequencing for the microphone and arbitration of the
//               shared transmit slot between mic sample and kbd/mouse words.
// Revision    : 1.0 - initial release
// ============================================================================
module mic_stream_ctrl #(
    parameter logic [7:0]  CMD_REC_START = 8'hC7,
    parameter logic [7:0]  CMD_REC_STOP  = 8'hC8,
    parameter int unsigned MAX_MIC_BURST = 4,
    parameter logic [15:0] STARVE_LIMIT  = 16'd8192
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mic_stream_ctrl_if.master bus
);

    typedef enum logic [0:0] {
        REC_OFF = 1'b0,
        REC_ON  = 1'b1
    } rec_state_t;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    localparam logic [1:0] c_kind_none = 2'b00;
    localparam logic [1:0] c_kind_mic  = 2'b01;
    localparam logic [1:0] c_kind_kbd  = 2'b10;
    localparam logic [3:0] c_max_burst = 4'(MAX_MIC_BURST);

    rec_state_t  rec_state_q, rec_state_d;
    logic        record_start_q, record_start_d;
    logic        record_stop_q, record_stop_d;

    tx_state_t   tx_state_q, tx_state_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic [1:0]  tx_kind_q, tx_kind_d;
    logic        retrieved_q, retrieved_d;
    logic        kbd_ack_q, kbd_ack_d;
    logic [3:0]  burst_q, burst_d;

    logic [15:0] starve_cnt_q, starve_cnt_d;
    logic        starve_q, starve_d;

    logic        w_recording;
    logic        w_start_accept;
    logic        w_stop_accept;
    logic        w_mic_hold;
    logic        w_mic_ok;
    logic        w_tx_idle;
    logic        w_grant_kbd;
    logic        w_grant_mic;

    assign w_recording    = (rec_state_q == REC_ON);
    assign w_start_accept = bus.cmd_valid && (bus.cmd_code == CMD_REC_START) && !w_recording;
    assign w_stop_accept  = bus.cmd_valid && (bus.cmd_code == CMD_REC_STOP) && w_recording;

    // The microphone refreshes mic_data_valid on the falling edge after it sees
    // the retrieve pulse, so the valid seen alongside that pulse is stale.
    assign w_mic_hold  = retrieved_q;
    assign w_mic_ok    = bus.mic_data_valid && w_recording && !w_mic_hold;
    assign w_tx_idle   = (tx_state_q == TX_IDLE);
    assign w_grant_kbd = w_tx_idle && bus.kbd_valid && (!w_mic_ok || (burst_q == c_max_burst));
    assign w_grant_mic = w_tx_idle && !w_grant_kbd && w_mic_ok;

    // ------------------------------------------------------------------
    // Record FSM
    // ------------------------------------------------------------------
    always_comb begin
        rec_state_d    = rec_state_q;
        record_start_d = 1'b0;
        record_stop_d  = 1'b0;
        case (rec_state_q)
            REC_OFF: begin
                if (w_start_accept) begin
                    rec_state_d    = REC_ON;
                    record_start_d = 1'b1;
                end
            end
            REC_ON: begin
                if (w_stop_accept) begin
                    rec_state_d   = REC_OFF;
                    record_stop_d = 1'b1;
                end
            end
            default: rec_state_d = REC_OFF;
        endcase
    end

    // ------------------------------------------------------------------
    // Transmit slot arbiter
    // ------------------------------------------------------------------
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_data_d   = tx_data_q;
        tx_kind_d   = tx_kind_q;
        retrieved_d = 1'b0;
        kbd_ack_d   = 1'b0;
        burst_d     = burst_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (w_grant_kbd) begin
                    tx_state_d = TX_BUSY;
                    tx_data_d  = bus.kbd_data;
                    tx_kind_d  = c_kind_kbd;
                    kbd_ack_d  = 1'b1;
                    burst_d    = 4'd0;
                end else if (w_grant_mic) begin
                    tx_state_d  = TX_BUSY;
                    tx_data_d   = bus.mic_data;
                    tx_kind_d   = c_kind_mic;
                    retrieved_d = 1'b1;
                    // Burst only tracks mic grants made while a kbd word waits
                    if (!bus.kbd_valid) begin
                        burst_d = 4'd0;
                    end else if (burst_q != c_max_burst) begin
                        burst_d = burst_q + 4'd1;
                    end
                end
            end
            TX_BUSY: begin
                if (bus.tx_ready) begin
                    tx_state_d = TX_IDLE;
                    tx_kind_d  = c_kind_none;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Starvation watchdog
    // ------------------------------------------------------------------
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        starve_d     = starve_q;
        if (w_start_accept) begin
            starve_cnt_d = 16'd0;
            starve_d     = 1'b0;
        end else if (w_recording) begin
            if (w_grant_mic) begin
                starve_cnt_d = 16'd0;
            end else if (starve_cnt_q != STARVE_LIMIT) begin
                starve_cnt_d = starve_cnt_q + 16'd1;
            end
            if (!w_grant_mic && (starve_cnt_d == STARVE_LIMIT)) begin
                starve_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_state_q    <= REC_OFF;
            record_start_q <= 1'b0;
            record_stop_q  <= 1'b0;
            tx_state_q     <= TX_IDLE;
            tx_data_q      <= 32'd0;
            tx_kind_q      <= c_kind_none;
            retrieved_q    <= 1'b0;
            kbd_ack_q      <= 1'b0;
            burst_q        <= 4'd0;
            starve_cnt_q   <= 16'd0;
            starve_q       <= 1'b0;
        end else begin
            rec_state_q    <= rec_state_d;
            record_start_q <= record_start_d;
            record_stop_q  <= record_stop_d;
            tx_state_q     <= tx_state_d;
            tx_data_q      <= tx_data_d;
            tx_kind_q      <= tx_kind_d;
            retrieved_q    <= retrieved_d;
            kbd_ack_q      <= kbd_ack_d;
            burst_q        <= burst_d;
            starve_cnt_q   <= starve_cnt_d;
            starve_q       <= starve_d;
        end
    end

    assign bus.record_start       = record_start_q;
    assign bus.record_stop        = record_stop_q;
    assign bus.mic_data_retrieved = retrieved_q;
    assign bus.kbd_ack            = kbd_ack_q;
    assign bus.tx_data            = tx_data_q;
    assign bus.tx_kind            = tx_kind_q;
    assign bus.tx_valid           = (tx_state_q == TX_BUSY);
    assign bus.recording          = w_recording;
    assign bus.starve             = starve_q;

endmodule
`default_nettype wire
